// File: rtl/fp_norm_seq_if.sv
// Operand/result handshake bundle for the float normaliser.
// The slave modport is the normaliser; the master modport is the producer/consumer side.
interface fp_norm_seq_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [FRAC_W+1:0] in_mant;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [FRAC_W-1:0] out_frac;
    logic              out_zero;
    logic              out_ovf;
    logic              out_unf;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_frac, out_zero, out_ovf, out_unf
    );
endinterface

// File: rtl/fp_norm_seq.sv
// Multi-cycle float normaliser: shifts the post-add mantissa until the hidden bit is set,
// at most STEP bits per cycle, adjusting the exponent and flagging zero/overflow/underflow.
module fp_norm_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int STEP   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_norm_seq_if.slave  bus
);
    localparam int MANT_W = FRAC_W + 2;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

    state_t            r_state;
    logic [MANT_W-1:0] r_mant;
    logic [EXP_W-1:0]  r_exp;
    logic              r_sign;
    logic              r_valid;
    logic              r_zero;
    logic              r_ovf;
    logic              r_unf;

    int                w_lz;
    int                w_k;
    logic [EXP_W-1:0]  w_exp_inc;

    // Leading zeros of the hidden+fraction field; ascending scan so the highest set bit wins.
    always_comb begin
        w_lz = FRAC_W + 1;
        for (int i = 0; i <= FRAC_W; i++) begin
            if (r_mant[i]) w_lz = FRAC_W - i;
        end
        w_k = (w_lz < STEP) ? w_lz : STEP;
    end

    assign w_exp_inc = bus.in_exp + EXP_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mant  <= '0;
            r_exp   <= '0;
            r_sign  <= 1'b0;
            r_valid <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_sign <= bus.in_sign;
                        r_zero <= 1'b0;
                        r_ovf  <= 1'b0;
                        r_unf  <= 1'b0;
                        if (bus.in_exp == EXP_MAX) begin
                            r_exp   <= EXP_MAX;
                            r_mant  <= '0;
                            r_ovf   <= 1'b1;
                            r_valid <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (bus.in_mant == '0) begin
                            r_exp   <= '0;
                            r_mant  <= '0;
                            r_zero  <= 1'b1;
                            r_valid <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (bus.in_mant[MANT_W-1]) begin
                            // Carry out of the add: renormalise right by one, truncating the LSB.
                            r_exp <= w_exp_inc;
                            if (w_exp_inc == EXP_MAX) begin
                                r_mant <= '0;
                                r_ovf  <= 1'b1;
                            end else begin
                                r_mant <= bus.in_mant >> 1;
                            end
                            r_valid <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (bus.in_mant[FRAC_W]) begin
                            r_exp   <= bus.in_exp;
                            r_mant  <= bus.in_mant;
                            r_valid <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_exp   <= bus.in_exp;
                            r_mant  <= bus.in_mant;
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    // Exponent would reach zero or below: flush rather than produce a subnormal.
                    if (int'(r_exp) <= w_k) begin
                        r_exp   <= '0;
                        r_mant  <= '0;
                        r_zero  <= 1'b1;
                        r_unf   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_mant <= r_mant << w_k;
                        r_exp  <= r_exp - EXP_W'(w_k);
                        if (w_k == w_lz) begin
                            r_valid <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_valid;
    assign bus.out_sign  = r_sign;
    assign bus.out_exp   = r_exp;
    assign bus.out_frac  = r_mant[FRAC_W-1:0];
    assign bus.out_zero  = r_zero;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_unf   = r_unf;
endmodule

// File: tb/tb_fp_norm_seq.sv
// Directed-vector bench for fp_norm_seq (EXP_W=8, FRAC_W=23, STEP=4).
module tb_fp_norm_seq;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    fp_norm_seq_if #(.EXP_W(8), .FRAC_W(23)) bus ();

    fp_norm_seq #(.EXP_W(8), .FRAC_W(23), .STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Presents one operand for a single accept edge, then counts edges until out_valid.
    task automatic apply(input logic s, input logic [7:0] e, input logic [24:0] m,
                         output int lat, output bit rdy_hi);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e;
        bus.in_mant  = m;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat    = 1;
        rdy_hi = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) rdy_hi = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (bus.in_ready) rdy_hi = 1'b1;
        $display("txn sign=%0b exp=%0d mant=%h -> lat=%0d out exp=%0d frac=%h z=%0b o=%0b u=%0b",
                 s, e, m, lat, bus.out_exp, bus.out_frac, bus.out_zero, bus.out_ovf, bus.out_unf);
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if ({bus.out_sign, bus.out_exp, bus.out_frac, bus.out_zero, bus.out_ovf, bus.out_unf} !== 35'd0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", {bus.out_sign, bus.out_exp, bus.out_frac, bus.out_zero, bus.out_ovf, bus.out_unf});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_hidden();
        int lat; bit rdy;
        apply(1'b1, 8'd100, 25'h0C00000, lat, rdy);
        checks++; if (lat !== 1) begin errors++; $display("FAIL hidden_latency got=%0d exp=1", lat); end
        checks++; if (bus.out_exp !== 8'd100) begin errors++; $display("FAIL hidden_exp got=%0d exp=100", bus.out_exp); end
        checks++; if (bus.out_frac !== 23'h400000) begin errors++; $display("FAIL hidden_frac got=%h exp=400000", bus.out_frac); end
        checks++; if (bus.out_sign !== 1'b1) begin errors++; $display("FAIL hidden_sign got=%0b exp=1", bus.out_sign); end
        checks++; if ({bus.out_zero, bus.out_ovf, bus.out_unf} !== 3'b000) begin errors++; $display("FAIL hidden_flags got=%b exp=000", {bus.out_zero, bus.out_ovf, bus.out_unf}); end
        pop();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL hidden_pop got valid=%0b ready=%0b exp valid=0 ready=1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_carry();
        int lat; bit rdy;
        apply(1'b0, 8'd127, 25'h1000001, lat, rdy);
        checks++; if (lat !== 1) begin errors++; $display("FAIL carry_latency got=%0d exp=1", lat); end
        checks++; if (bus.out_exp !== 8'd128) begin errors++; $display("FAIL carry_exp got=%0d exp=128", bus.out_exp); end
        checks++; if (bus.out_frac !== 23'h000000) begin errors++; $display("FAIL carry_frac got=%h exp=000000", bus.out_frac); end
        checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL carry_ovf got=%0b exp=0", bus.out_ovf); end
        pop();
        apply(1'b0, 8'd254, 25'h1800000, lat, rdy);
        checks++; if (bus.out_exp !== 8'd255) begin errors++; $display("FAIL carry_sat_exp got=%0d exp=255", bus.out_exp); end
        checks++; if (bus.out_ovf !== 1'b1 || bus.out_zero !== 1'b0) begin errors++; $display("FAIL carry_sat_flags got ovf=%0b zero=%0b exp ovf=1 zero=0", bus.out_ovf, bus.out_zero); end
        checks++; if (bus.out_frac !== 23'h000000) begin errors++; $display("FAIL carry_sat_frac got=%h exp=000000", bus.out_frac); end
        pop();
        apply(1'b0, 8'd255, 25'h0C00000, lat, rdy);
        checks++; if (bus.out_ovf !== 1'b1 || bus.out_exp !== 8'd255 || bus.out_frac !== 23'h0) begin
            errors++; $display("FAIL inf_in got ovf=%0b exp=%0d frac=%h exp ovf=1 exp=255 frac=0", bus.out_ovf, bus.out_exp, bus.out_frac);
        end
        pop();
    endtask

    task automatic test_shift();
        int lat; bit rdy;
        apply(1'b0, 8'd127, 25'h0004000, lat, rdy);
        checks++; if (lat !== 4) begin errors++; $display("FAIL shift9_latency got=%0d exp=4", lat); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL shift9_in_ready got=1 exp=0 while busy"); end
        checks++; if (bus.out_exp !== 8'd118) begin errors++; $display("FAIL shift9_exp got=%0d exp=118", bus.out_exp); end
        checks++; if (bus.out_frac !== 23'h0 || {bus.out_zero, bus.out_ovf, bus.out_unf} !== 3'b000) begin
            errors++; $display("FAIL shift9_frac got frac=%h flags=%b exp frac=0 flags=000", bus.out_frac, {bus.out_zero, bus.out_ovf, bus.out_unf});
        end
        pop();
        apply(1'b1, 8'd50, 25'h0000003, lat, rdy);
        checks++; if (lat !== 7) begin errors++; $display("FAIL shift22_latency got=%0d exp=7", lat); end
        checks++; if (bus.out_exp !== 8'd28 || bus.out_frac !== 23'h400000) begin
            errors++; $display("FAIL shift22_result got exp=%0d frac=%h exp exp=28 frac=400000", bus.out_exp, bus.out_frac);
        end
        pop();
    endtask

    task automatic test_underflow();
        int lat; bit rdy;
        apply(1'b0, 8'd5, 25'h0000100, lat, rdy);
        checks++; if (lat !== 3) begin errors++; $display("FAIL unf_latency got=%0d exp=3", lat); end
        checks++; if ({bus.out_zero, bus.out_ovf, bus.out_unf} !== 3'b101 || bus.out_exp !== 8'd0 || bus.out_frac !== 23'h0) begin
            errors++; $display("FAIL unf_result got flags=%b exp=%0d frac=%h exp flags=101 exp=0 frac=0", {bus.out_zero, bus.out_ovf, bus.out_unf}, bus.out_exp, bus.out_frac);
        end
        pop();
        apply(1'b0, 8'd77, 25'h0000000, lat, rdy);
        checks++; if (lat !== 1 || {bus.out_zero, bus.out_ovf, bus.out_unf} !== 3'b100 || bus.out_exp !== 8'd0) begin
            errors++; $display("FAIL zero_in got lat=%0d flags=%b exp=%0d exp lat=1 flags=100 exp=0", lat, {bus.out_zero, bus.out_ovf, bus.out_unf}, bus.out_exp);
        end
        pop();
        apply(1'b0, 8'd0, 25'h0000001, lat, rdy);
        checks++; if (lat !== 2 || {bus.out_zero, bus.out_ovf, bus.out_unf} !== 3'b101) begin
            errors++; $display("FAIL subnormal got lat=%0d flags=%b exp lat=2 flags=101", lat, {bus.out_zero, bus.out_ovf, bus.out_unf});
        end
        pop();
    endtask

    task automatic test_back_to_back();
        int lat; bit rdy;
        apply(1'b0, 8'd60, 25'h0A00000, lat, rdy);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_exp !== 8'd60 || bus.out_frac !== 23'h200000) begin
                errors++; $display("FAIL hold_cycle%0d got valid=%0b ready=%0b exp=%0d frac=%h exp valid=1 ready=0 exp=60 frac=200000",
                                   c, bus.out_valid, bus.in_ready, bus.out_exp, bus.out_frac);
            end
        end
        pop();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got valid=%0b ready=%0b exp valid=0 ready=1", bus.out_valid, bus.in_ready); end
        apply(1'b1, 8'd10, 25'h0200000, lat, rdy);
        checks++; if (lat !== 2 || bus.out_exp !== 8'd8 || bus.out_frac !== 23'h0 || bus.out_sign !== 1'b1 || bus.out_zero !== 1'b0) begin
            errors++; $display("FAIL b2b_next got lat=%0d exp=%0d frac=%h sign=%0b zero=%0b exp lat=2 exp=8 frac=0 sign=1 zero=0",
                               lat, bus.out_exp, bus.out_frac, bus.out_sign, bus.out_zero);
        end
        pop();
    endtask

    task automatic test_reset_mid();
        int lat; bit rdy; bit seen;
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 8'd50;
        bus.in_mant  = 25'h0000003;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid got valid=%0b ready=%0b exp valid=0 ready=1", bus.out_valid, bus.in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        $display("txn reset during SHIFT, out_valid seen afterwards=%0b", seen);
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_dropped got out_valid=1 exp=0"); end
        apply(1'b0, 8'd100, 25'h0C00000, lat, rdy);
        checks++; if (lat !== 1 || bus.out_exp !== 8'd100 || bus.out_frac !== 23'h400000) begin
            errors++; $display("FAIL rst_mid_resume got lat=%0d exp=%0d frac=%h exp lat=1 exp=100 frac=400000", lat, bus.out_exp, bus.out_frac);
        end
        pop();
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_hidden();
        test_carry();
        test_shift();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
